// File: rtl/hockey_pkg.sv
// Shared encodings for the hockey match sequencer: FSM states, player ids,
// direction codes and the default serve Y position.
// Config macro: HOCKEY_SERVE_TIMEOUT_EN (consumed by hockey_match_ctrl).
package hockey_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    RALLY     = 3'd2,
    ISSUE     = 3'd3,
    GAME_OVER = 3'd4
  } state_e;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

  localparam logic [1:0] DIR_STRAIGHT = 2'd0;
  localparam logic [1:0] DIR_UP       = 2'd1;
  localparam logic [1:0] DIR_DOWN     = 2'd2;
  localparam logic [1:0] DIR_ILLEGAL  = 2'd3;

  localparam logic [2:0] Y_CENTER = 3'd2;

  // A direction is usable for a hit unless it is the reserved code
  function automatic logic dir_legal(input logic [1:0] dir);
    return dir != DIR_ILLEGAL;
  endfunction

endpackage

// File: rtl/hockey_btn_edge.sv
// Per-player button front end: rising-edge press detect plus legal-direction qualify.
// Latency: combinational press outputs from the current button level and one history flop.
// Backpressure: none; a held button produces a single press.
module hockey_btn_edge
  import hockey_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  input  logic [1:0] dir_i,
  output logic       press_o,
  output logic       legal_o
);

  logic btn_q;

  // Button history for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
    end
  end

  assign press_o = btn_i & ~btn_q;
  assign legal_o = press_o & dir_legal(dir_i);

endmodule

// File: rtl/hockey_match_ctrl.sv
// Match sequencer: arbitrates player presses, issues one hit command at a time, keeps score.
// Latency: press cycle -> hit_valid one cycle later; goals update score on the next edge.
// Backpressure: hit command held stable while hit_ready is low. Macro HOCKEY_SERVE_TIMEOUT_EN adds auto-serve.
module hockey_match_ctrl
  import hockey_pkg::*;
#(
  parameter int WIN_SCORE     = 3,
  parameter int SCORE_W       = 3,
  parameter int SERVE_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_a,
  input  logic               btn_b,
  input  logic [1:0]         dir_a,
  input  logic [1:0]         dir_b,
  input  logic [2:0]         y_a,
  input  logic [2:0]         y_b,
  input  logic               goal_a,
  input  logic               goal_b,
  input  logic               hit_ready,
  output logic               hit_valid,
  output logic               hit_player,
  output logic [1:0]         hit_dir,
  output logic [2:0]         hit_y,
  output logic               turn,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_SCORE);

  logic press_a, press_b, legal_a, legal_b;

  hockey_btn_edge u_edge_a (
    .clk(clk), .rst(rst), .btn_i(btn_a), .dir_i(dir_a), .press_o(press_a), .legal_o(legal_a)
  );
  hockey_btn_edge u_edge_b (
    .clk(clk), .rst(rst), .btn_i(btn_b), .dir_i(dir_b), .press_o(press_b), .legal_o(legal_b)
  );

  state_e             state_q, state_d;
  logic               turn_q, hit_player_q, winner_q;
  logic [1:0]         hit_dir_q;
  logic [2:0]         hit_y_q;
  logic [SCORE_W-1:0] score_a_q, score_b_q;

  // Next-cycle actions decided by the FSM
  logic               cap_en, cap_player, inc_a, inc_b, flip, clear;
  logic [1:0]         cap_dir;
  logic [2:0]         cap_y;
  logic               timeout;

  // Only the player whose turn it is may hit in SERVE and RALLY
  logic               turn_legal;
  logic [1:0]         turn_dir;
  logic [2:0]         turn_y;
  logic [SCORE_W-1:0] sa_inc, sb_inc;

  assign turn_legal = turn_q ? legal_b : legal_a;
  assign turn_dir   = turn_q ? dir_b : dir_a;
  assign turn_y     = turn_q ? y_b : y_a;
  assign sa_inc     = score_a_q + 1'b1;
  assign sb_inc     = score_b_q + 1'b1;

`ifdef HOCKEY_SERVE_TIMEOUT_EN
  localparam int TW = (SERVE_TIMEOUT > 1) ? $clog2(SERVE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(SERVE_TIMEOUT - 1);
  logic [TW-1:0] tmr_q;

  // Serve wait counter: zero outside SERVE, counts SERVE cycles up to the timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q <= '0;
    end else if (state_q != SERVE) begin
      tmr_q <= '0;
    end else if (tmr_q != TMO_LAST) begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  assign timeout = (state_q == SERVE) && (tmr_q == TMO_LAST);
`else
  assign timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle actions; goals outrank presses in RALLY
  always_comb begin
    state_d    = state_q;
    cap_en     = 1'b0;
    cap_player = turn_q;
    cap_dir    = turn_dir;
    cap_y      = turn_y;
    inc_a      = 1'b0;
    inc_b      = 1'b0;
    flip       = 1'b0;
    clear      = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal_a) begin
          cap_en = 1'b1; cap_player = PLAYER_A; cap_dir = dir_a; cap_y = y_a;
          state_d = ISSUE;
        end else if (legal_b) begin
          cap_en = 1'b1; cap_player = PLAYER_B; cap_dir = dir_b; cap_y = y_b;
          state_d = ISSUE;
        end
      end
      SERVE: begin
        if (turn_legal) begin
          cap_en = 1'b1;
          state_d = ISSUE;
        end else if (timeout) begin
          cap_en = 1'b1; cap_dir = DIR_STRAIGHT; cap_y = Y_CENTER;
          state_d = ISSUE;
        end
      end
      RALLY: begin
        if (goal_a) begin
          inc_a = 1'b1;
          state_d = (sa_inc == WIN_V) ? GAME_OVER : SERVE;
        end else if (goal_b) begin
          inc_b = 1'b1;
          state_d = (sb_inc == WIN_V) ? GAME_OVER : SERVE;
        end else if (turn_legal) begin
          cap_en = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hit_ready) begin
          flip = 1'b1;
          state_d = RALLY;
        end
      end
      GAME_OVER: begin
        if (press_a && press_b) begin
          clear = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Captured command, turn, scores and winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      turn_q       <= PLAYER_A;
      hit_player_q <= PLAYER_A;
      hit_dir_q    <= '0;
      hit_y_q      <= '0;
      score_a_q    <= '0;
      score_b_q    <= '0;
      winner_q     <= PLAYER_A;
    end else if (cap_en) begin
      hit_player_q <= cap_player;
      hit_dir_q    <= cap_dir;
      hit_y_q      <= cap_y;
      turn_q       <= cap_player;
    end else if (flip) begin
      turn_q <= ~turn_q;
    end else if (inc_a) begin
      score_a_q <= sa_inc;
      turn_q    <= PLAYER_B;
      if (sa_inc == WIN_V) winner_q <= PLAYER_A;
    end else if (inc_b) begin
      score_b_q <= sb_inc;
      turn_q    <= PLAYER_A;
      if (sb_inc == WIN_V) winner_q <= PLAYER_B;
    end else if (clear) begin
      score_a_q <= '0;
      score_b_q <= '0;
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    hit_valid = (state_q == ISSUE);
    game_over = (state_q == GAME_OVER);
  end

  assign hit_player = hit_player_q;
  assign hit_dir    = hit_dir_q;
  assign hit_y      = hit_y_q;
  assign turn       = turn_q;
  assign score_a    = score_a_q;
  assign score_b    = score_b_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_hockey_match_ctrl.sv
module tb_hockey_match_ctrl;

  localparam int WIN = 3;
  localparam int SW  = 3;
  localparam int TMO = 16;

  typedef struct {
    logic ba, bb;
    logic [1:0] da, db;
    logic [2:0] ya, yb;
    logic ga, gb, rdy;
  } stim_t;

  typedef struct {
    logic vld, pl;
    logic [1:0] dir;
    logic [2:0] y;
    logic turn;
    logic [SW-1:0] sa, sb;
    logic over, win;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  typedef struct {
    logic pl;
    logic [1:0] dir;
    logic [2:0] y;
  } hit_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_a = 0, btn_b = 0, goal_a = 0, goal_b = 0, hit_ready = 0;
  logic [1:0] dir_a = 0, dir_b = 0;
  logic [2:0] y_a = 0, y_b = 0;
  logic hit_valid, hit_player, turn, game_over, winner;
  logic [1:0] hit_dir;
  logic [2:0] hit_y;
  logic [SW-1:0] score_a, score_b;

  int vectors = 0;
  int miscompares = 0;

  hockey_match_ctrl #(.WIN_SCORE(WIN), .SCORE_W(SW), .SERVE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .btn_a(btn_a), .btn_b(btn_b), .dir_a(dir_a), .dir_b(dir_b),
    .y_a(y_a), .y_b(y_b), .goal_a(goal_a), .goal_b(goal_b),
    .hit_ready(hit_ready), .hit_valid(hit_valid), .hit_player(hit_player),
    .hit_dir(hit_dir), .hit_y(hit_y), .turn(turn),
    .score_a(score_a), .score_b(score_b), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk_s(input int ba, bb, da, db, ya, yb, ga, gb, rdy);
    stim_t s;
    s.ba = 1'(ba); s.bb = 1'(bb); s.da = 2'(da); s.db = 2'(db);
    s.ya = 3'(ya); s.yb = 3'(yb); s.ga = 1'(ga); s.gb = 1'(gb); s.rdy = 1'(rdy);
    return s;
  endfunction

  function automatic exp_t mk_e(input int vld, pl, dir, y, trn, sa, sb, over, win);
    exp_t e;
    e.vld = 1'(vld); e.pl = 1'(pl); e.dir = 2'(dir); e.y = 3'(y); e.turn = 1'(trn);
    e.sa = SW'(sa); e.sb = SW'(sb); e.over = 1'(over); e.win = 1'(win);
    return e;
  endfunction

  task automatic drive(input stim_t s);
    btn_a = s.ba; btn_b = s.bb; dir_a = s.da; dir_b = s.db;
    y_a = s.ya; y_b = s.yb; goal_a = s.ga; goal_b = s.gb; hit_ready = s.rdy;
  endtask

  task automatic apply(input stim_t s);
    @(negedge clk);
    drive(s);
    @(posedge clk);
    #1;
  endtask

  // winner is only meaningful while game_over is expected
  task automatic check(input string nm, input exp_t e);
    logic ok;
    ok = (hit_valid === e.vld) && (hit_player === e.pl) && (hit_dir === e.dir) &&
         (hit_y === e.y) && (turn === e.turn) && (score_a === e.sa) &&
         (score_b === e.sb) && (game_over === e.over) && (!e.over || winner === e.win);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s @%0t: got vld=%b pl=%b dir=%0d y=%0d turn=%b sa=%0d sb=%0d over=%b win=%b, want vld=%b pl=%b dir=%0d y=%0d turn=%b sa=%0d sb=%0d over=%b win=%b",
               nm, $time, hit_valid, hit_player, hit_dir, hit_y, turn, score_a, score_b, game_over, winner,
               e.vld, e.pl, e.dir, e.y, e.turn, e.sa, e.sb, e.over, e.win);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset", mk_e(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- reference model (match rules, not FSM encoding) ----------------
  int   m_phase;      // 0 waiting for any first press, 1 waiting for serve, 2 puck live
  bit   m_over;
  hit_t m_pend[$];    // command offered to the datapath, not yet accepted
  hit_t m_last;
  bit   m_turn, m_win, m_pa, m_pb;
  int   m_sa, m_sb, m_wait;

  task automatic m_reset();
    m_phase = 0; m_over = 0; m_pend.delete();
    m_last = '{pl: 0, dir: 0, y: 0};
    m_turn = 0; m_win = 0; m_pa = 0; m_pb = 0; m_sa = 0; m_sb = 0; m_wait = 0;
  endtask

  task automatic m_capture(input bit p, input logic [1:0] d, input logic [2:0] y);
    hit_t h;
    h.pl = p; h.dir = d; h.y = y;
    m_pend.push_back(h);
    m_last = h;
    m_turn = p;
  endtask

  task automatic m_step(input stim_t s);
    bit pa, pb, la, lb, tl, was_serve;
    pa = s.ba && !m_pa;
    pb = s.bb && !m_pb;
    la = pa && (s.da != 2'd3);
    lb = pb && (s.db != 2'd3);
    tl = m_turn ? lb : la;
    was_serve = !m_over && m_pend.size() == 0 && m_phase == 1;
    if (m_over) begin
      if (pa && pb) begin m_sa = 0; m_sb = 0; m_over = 0; m_phase = 0; end
    end else if (m_pend.size() != 0) begin
      if (s.rdy) begin void'(m_pend.pop_front()); m_turn = !m_turn; m_phase = 2; end
    end else if (m_phase == 0) begin
      if (la) m_capture(0, s.da, s.ya);
      else if (lb) m_capture(1, s.db, s.yb);
    end else if (m_phase == 2) begin
      if (s.ga) begin
        m_sa++; m_turn = 1;
        if (m_sa == WIN) begin m_over = 1; m_win = 0; end else m_phase = 1;
      end else if (s.gb) begin
        m_sb++; m_turn = 0;
        if (m_sb == WIN) begin m_over = 1; m_win = 1; end else m_phase = 1;
      end else if (tl) begin
        m_capture(m_turn, m_turn ? s.db : s.da, m_turn ? s.yb : s.ya);
      end
    end else begin
      if (tl) m_capture(m_turn, m_turn ? s.db : s.da, m_turn ? s.yb : s.ya);
`ifdef HOCKEY_SERVE_TIMEOUT_EN
      else if (m_wait == TMO - 1) m_capture(m_turn, 2'd0, 3'd2);
`endif
    end
    if (!m_over && m_pend.size() == 0 && m_phase == 1) m_wait = was_serve ? m_wait + 1 : 0;
    else m_wait = 0;
    m_pa = s.ba; m_pb = s.bb;
  endtask

  function automatic exp_t m_exp();
    return mk_e(m_pend.size() != 0, m_last.pl, m_last.dir, m_last.y, m_turn,
                m_sa, m_sb, m_over, m_win);
  endfunction

  // ---------------- directed table from reset ----------------
  vec_t tbl[$];

  initial begin
    stim_t s;
    bit seen;

    tbl.push_back('{mk_s(0,0,0,0,0,0,0,0,0), mk_e(0,0,0,0,0,0,0,0,0)});
    tbl.push_back('{mk_s(1,0,1,0,1,0,0,0,1), mk_e(1,0,1,1,0,0,0,0,0)}); // A serves from IDLE
    tbl.push_back('{mk_s(1,0,1,0,1,0,0,0,1), mk_e(0,0,1,1,1,0,0,0,0)}); // accepted, turn B
    tbl.push_back('{mk_s(0,0,0,0,0,0,1,0,0), mk_e(0,0,1,1,1,1,0,0,0)}); // goal_a -> SERVE, B serves
    tbl.push_back('{mk_s(1,0,0,0,0,0,0,0,0), mk_e(0,0,1,1,1,1,0,0,0)}); // A press ignored
    tbl.push_back('{mk_s(0,1,0,0,0,2,0,0,0), mk_e(1,1,0,2,1,1,0,0,0)}); // B serves {1,0,2}
    tbl.push_back('{mk_s(0,1,0,1,0,5,0,0,0), mk_e(1,1,0,2,1,1,0,0,0)}); // stall 1
    tbl.push_back('{mk_s(0,1,0,1,0,5,0,1,0), mk_e(1,1,0,2,1,1,0,0,0)}); // stall 2, goal_b ignored
    tbl.push_back('{mk_s(0,1,0,1,0,5,0,0,0), mk_e(1,1,0,2,1,1,0,0,0)}); // stall 3
    tbl.push_back('{mk_s(0,1,0,1,0,5,0,0,0), mk_e(1,1,0,2,1,1,0,0,0)}); // stall 4
    tbl.push_back('{mk_s(0,1,0,1,0,5,0,0,0), mk_e(1,1,0,2,1,1,0,0,0)}); // stall 5
    tbl.push_back('{mk_s(0,0,0,0,0,0,0,0,1), mk_e(0,1,0,2,0,1,0,0,0)}); // accepted, turn A
    tbl.push_back('{mk_s(0,0,0,0,0,0,1,1,0), mk_e(0,1,0,2,1,2,0,0,0)}); // dual goal -> only A
    tbl.push_back('{mk_s(0,1,0,3,0,4,0,0,0), mk_e(0,1,0,2,1,2,0,0,0)}); // illegal dir ignored
    tbl.push_back('{mk_s(0,0,0,0,0,0,0,0,0), mk_e(0,1,0,2,1,2,0,0,0)});
    tbl.push_back('{mk_s(0,1,0,2,0,7,0,0,1), mk_e(1,1,2,7,1,2,0,0,0)}); // B serves {1,2,7}
    tbl.push_back('{mk_s(0,1,0,2,0,7,0,0,1), mk_e(0,1,2,7,0,2,0,0,0)});
    tbl.push_back('{mk_s(0,0,0,0,0,0,1,0,0), mk_e(0,1,2,7,1,3,0,1,0)}); // A reaches 3 -> over
    tbl.push_back('{mk_s(0,0,0,0,0,0,0,1,0), mk_e(0,1,2,7,1,3,0,1,0)}); // goals ignored
    tbl.push_back('{mk_s(0,0,0,0,0,0,1,0,0), mk_e(0,1,2,7,1,3,0,1,0)});
    tbl.push_back('{mk_s(1,0,1,0,1,0,0,0,0), mk_e(0,1,2,7,1,3,0,1,0)}); // single press ignored
    tbl.push_back('{mk_s(0,0,0,0,0,0,0,0,0), mk_e(0,1,2,7,1,3,0,1,0)});
    tbl.push_back('{mk_s(1,1,1,1,1,1,0,0,0), mk_e(0,1,2,7,1,0,0,0,0)}); // dual press -> IDLE
    tbl.push_back('{mk_s(0,0,0,0,0,0,0,0,0), mk_e(0,1,2,7,1,0,0,0,0)});
    tbl.push_back('{mk_s(1,1,2,1,3,6,0,0,0), mk_e(1,0,2,3,0,0,0,0,0)}); // tie in IDLE -> A
    tbl.push_back('{mk_s(1,1,2,1,3,6,0,0,1), mk_e(0,0,2,3,1,0,0,0,0)});
    tbl.push_back('{mk_s(0,0,0,0,0,0,0,0,0), mk_e(0,0,2,3,1,0,0,0,0)});
    tbl.push_back('{mk_s(0,1,0,1,0,1,0,1,0), mk_e(0,0,2,3,0,0,1,0,0)}); // goal beats press
    tbl.push_back('{mk_s(0,0,0,0,0,0,0,0,0), mk_e(0,0,2,3,0,0,1,0,0)});
    tbl.push_back('{mk_s(0,1,0,1,0,1,0,0,0), mk_e(0,0,2,3,0,0,1,0,0)}); // off-turn press ignored
    tbl.push_back('{mk_s(1,0,1,0,4,0,0,0,1), mk_e(1,0,1,4,0,0,1,0,0)}); // A serves {0,1,4}

    do_reset();
    foreach (tbl[i]) begin
      apply(tbl[i].s);
      check($sformatf("tbl%0d", i), tbl[i].e);
    end

    // Asynchronous reset while a command is pending; nothing replays afterwards
    apply(mk_s(0,0,0,0,0,0,0,0,0));
    check("issue_hold", mk_e(1,0,1,4,0,0,1,0,0));
    #2 rst = 1'b0;
    #1 check("async_rst", mk_e(0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) apply(mk_s(0,0,0,0,0,0,0,0,1));
    check("no_replay", mk_e(0,0,0,0,0,0,0,0,0));

    // Serve timeout behaviour
    do_reset();
    apply(mk_s(1,0,1,0,1,0,0,0,1));
    apply(mk_s(1,0,1,0,1,0,0,0,1));
    apply(mk_s(0,0,0,0,0,0,1,0,0));
    check("enter_serve", mk_e(0,0,1,1,1,1,0,0,0));
`ifdef HOCKEY_SERVE_TIMEOUT_EN
    repeat (TMO - 1) apply(mk_s(0,0,0,0,0,0,0,0,0));
    check("tmo_early", mk_e(0,0,1,1,1,1,0,0,0));
    apply(mk_s(0,0,0,0,0,0,0,0,0));
    check("tmo_fire", mk_e(1,1,0,2,1,1,0,0,0));
`else
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      apply(mk_s(0,0,0,0,0,0,0,0,0));
      if (hit_valid) seen = 1;
    end
    check("no_tmo", mk_e(seen, 0, 1, 1, 1, 1, 0, 0, 0));
    if (seen) $display("FAIL no_tmo: hit_valid rose during 100 idle SERVE cycles, required none");
`endif

    // Randomized play against the reference model
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      s.ba  = ($urandom % 3) == 0;
      s.bb  = ($urandom % 3) == 0;
      s.da  = 2'($urandom % 4);
      s.db  = 2'($urandom % 4);
      s.ya  = 3'($urandom % 8);
      s.yb  = 3'($urandom % 8);
      s.ga  = ($urandom % 8) == 0;
      s.gb  = ($urandom % 8) == 0;
      s.rdy = ($urandom % 2) == 0;
      m_step(s);
      apply(s);
      check("rand", m_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hockey_match_ctrl.md
Name: hockey_match_ctrl

Overview:
Match sequencer in front of the hockey puck datapath. It arbitrates the two players' button/direction/Y inputs and decides whose turn it is to serve or return. It issues one hit command at a time to the datapath over a valid/ready handshake, and keeps score from the datapath's goal pulses. It declares game over at a target score.

Parameters:
WIN_SCORE, 3, score at which a player wins (1..2^SCORE_W-1)
SCORE_W, 3, width of each score counter
SERVE_TIMEOUT, 16, cycles allowed in SERVE before auto-serve (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
btn_a  in  1  player A hit button, synchronous level
btn_b  in  1  player B hit button, synchronous level
dir_a  in  2  A direction: 0 straight, 1 up, 2 down, 3 illegal
dir_b  in  2  B direction, same encoding
y_a  in  3  A paddle Y position
y_b  in  3  B paddle Y position
goal_a  in  1  one-cycle pulse: A scored (B missed)
goal_b  in  1  one-cycle pulse: B scored (A missed)
hit_ready  in  1  datapath accepts a hit command
hit_valid  out  1  hit command pending
hit_player  out  1  0 = A, 1 = B
hit_dir  out  2  captured direction
hit_y  out  3  captured Y
turn  out  1  player expected to hit next
score_a  out  SCORE_W  A score
score_b  out  SCORE_W  B score
game_over  out  1  match finished
winner  out  1  valid when game_over; 0 = A, 1 = B

Behaviour:
- Reset (rst=0, asynchronous) forces the following: state IDLE, all outputs 0, both button-history flops 0.
- Press = rising edge of the button: btn & ~btn_q, with btn_q registered each cycle. A held button yields one press only.
- A press carrying dir = 3 is ignored and captures nothing.
- IDLE:
  - The first legal press from either player sets turn to that player and captures dir/y; next state is ISSUE.
  - If both players press in the same cycle, A wins.
- SERVE and RALLY:
  - A legal press by the turn player captures {player, dir, y}; next state is ISSUE.
  - Presses by the other player are ignored.
- ISSUE:
  - hit_valid = 1, and hit_player/dir/y stay stable until the handshake completes.
  - Transfer happens in the cycle where hit_valid & hit_ready; hit_valid drops the next cycle, turn flips, next state is RALLY.
  - Latency from press cycle to hit_valid high is 1 cycle.
- Goal handling in RALLY:
  - goal_a increments score_a and sets turn = B, so the conceding player serves. goal_b is symmetric.
  - If the incremented score equals WIN_SCORE: next state GAME_OVER, winner = scorer. Otherwise next state SERVE.
  - If goal_a and goal_b arrive in the same cycle, goal_a takes priority and goal_b is dropped.
  - A goal and a turn-player press in the same cycle: the goal wins and the press is discarded.
- Goals in IDLE, SERVE, ISSUE or GAME_OVER are ignored. The puck is either not live or a command is in flight.
- Scores never wrap. The WIN_SCORE check stops increments before overflow.
- GAME_OVER:
  - game_over = 1; scores and winner hold.
  - Simultaneous presses by both players clear scores and game_over and return to IDLE. Any other input is ignored.
- Reset mid-ISSUE drops hit_valid immediately, since reset is asynchronous. No command is replayed after reset.

Optional Feature:
HOCKEY_SERVE_TIMEOUT_EN.
- Defined: a counter clears on entry to SERVE and increments each SERVE cycle. When it reaches SERVE_TIMEOUT-1 with no legal press, the block auto-captures {turn, dir = 0, y = 2} and goes to ISSUE. A press in the same cycle as the timeout takes precedence.
- Undefined: no counter exists, and SERVE waits indefinitely.

Decomposition:
- hockey_pkg holds:
  - state encodings IDLE/SERVE/RALLY/ISSUE/GAME_OVER
  - PLAYER_A = 0, PLAYER_B = 1
  - DIR_STRAIGHT/UP/DOWN/ILLEGAL = 0/1/2/3
  - Y_CENTER = 2
- One sub-module, hockey_btn_edge: per-player rising-edge detector plus legal-direction qualify. It is instantiated twice.

Test Plan:
- Reset then A press (dir 1, y 1) with hit_ready = 1 -> hit_valid for 1 cycle carrying {0, 1, 1}; turn = B, state RALLY.
- In RALLY with turn = B: goal_a pulse -> score_a = 1, turn = B, state SERVE. A press by A is then ignored; B press (dir 0, y 2) -> hit {1, 0, 2}.
- hit_ready held 0 for 5 cycles -> hit_valid and payload stable for all 5; goal_b during this window leaves score_b unchanged.
- Same-cycle A and B presses in IDLE -> A serves. Same-cycle goal_a and goal_b -> only score_a increments. A press with dir 3 -> no hit_valid.
- Drive A to 3 goals with WIN_SCORE = 3 -> game_over = 1, winner = 0, score_a = 3. Further goals do not change scores; a dual press -> scores 0, state IDLE.
- With HOCKEY_SERVE_TIMEOUT_EN and SERVE_TIMEOUT = 16: enter SERVE and wait 16 cycles -> hit {turn, 0, 2}. With the macro undefined -> no hit after 100 cycles.
